// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
package if_prefetch_pkg;

  localparam int unsigned INST_BYTES   = 4;
  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_DROP = 2'b01,
    RESP_PUSH = 2'b10
  } resp_act_e;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, inst} pairs; flush empties it, en=0 freezes it.
module if_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             empty_s;
  logic             full_s;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == DEPTH_C);

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop_s  = en && !flush && pop && !empty_s;
  assign do_push_s = en && !flush && push && (!full_s || do_pop_s);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (en && flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only observable through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: credit-limited pipelined I-cache requests feeding a prefetch FIFO,
// with redirect handling that counts off stale in-flight responses.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned      XLEN            = XLEN_DEF,
  parameter int unsigned      DEPTH           = 4,
  parameter int unsigned      MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0]  RESET_PC        = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            cache_req_o,
  output logic [XLEN-1:0] cache_addr_o,
  input  logic            cache_gnt_i,
  input  logic            cache_rvalid_i,
  input  logic [XLEN-1:0] cache_rdata_i,
  output logic            queue_valid_o,
  output logic [XLEN-1:0] queue_inst_o,
  output logic [XLEN-1:0] queue_pc_o,
  input  logic            queue_ready_i
);

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   MAX_OUT_C  = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]     DEPTH_C    = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP_C     = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP_C - XLEN'(1'b1));

  logic [XLEN-1:0]   fetch_pc_r, fetch_pc_nx_s;
  logic [XLEN-1:0]   resp_pc_r, resp_pc_nx_s;
  logic [CW-1:0]     inflight_r, inflight_nx_s;
  logic [CW-1:0]     drop_r, drop_nx_s;
  logic [CW-1:0]     fifo_count_s;
  logic              fifo_empty_s;
  logic [2*XLEN-1:0] fifo_head_s;
  logic [CW:0]       credit_sum_s;
  logic              issue_s;
  logic              fire_s;
  logic              rsp_s;
  logic              push_s;
  logic              pop_s;
  logic              flush_s;
  resp_act_e         resp_act_s;

  // Every granted request owns a FIFO slot, so responses never need backpressure.
  always_comb begin
    credit_sum_s = {1'b0, fifo_count_s} + {1'b0, inflight_r};
    issue_s      = !redirect_i && (inflight_r < MAX_OUT_C) && (credit_sum_s < DEPTH_C);
    fire_s       = rdy && issue_s && cache_gnt_i;
    rsp_s        = rdy && cache_rvalid_i;
  end

  // Classify the response in flight this cycle.
  always_comb begin
    if (!cache_rvalid_i) begin
      resp_act_s = RESP_NONE;
    end else if (drop_r != {CW{1'b0}}) begin
      resp_act_s = RESP_DROP;
    end else begin
      resp_act_s = RESP_PUSH;
    end
  end

  // Next-state for PCs and counters; redirect overrides everything and marks all survivors stale.
  always_comb begin
    fetch_pc_nx_s = fetch_pc_r;
    resp_pc_nx_s  = resp_pc_r;
    drop_nx_s     = drop_r;
    inflight_nx_s = inflight_r + CW'(fire_s) - CW'(rsp_s);
    push_s        = 1'b0;
    pop_s         = 1'b0;
    flush_s       = 1'b0;
    if (!rdy) begin
      inflight_nx_s = inflight_r;
    end else if (redirect_i) begin
      fetch_pc_nx_s = redirect_pc_i & ALIGN_MASK;
      resp_pc_nx_s  = redirect_pc_i & ALIGN_MASK;
      drop_nx_s     = inflight_nx_s;
      flush_s       = 1'b1;
    end else begin
      if (fire_s) begin
        fetch_pc_nx_s = fetch_pc_r + STEP_C;
      end else begin
        fetch_pc_nx_s = fetch_pc_r;
      end
      case (resp_act_s)
        RESP_DROP: drop_nx_s = drop_r - CW'(1'b1);
        RESP_PUSH: begin
          push_s       = 1'b1;
          resp_pc_nx_s = resp_pc_r + STEP_C;
        end
        default:   drop_nx_s = drop_r;
      endcase
      pop_s = !fifo_empty_s && queue_ready_i;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      inflight_r <= {CW{1'b0}};
      drop_r     <= {CW{1'b0}};
    end else begin
      fetch_pc_r <= fetch_pc_nx_s;
      resp_pc_r  <= resp_pc_nx_s;
      inflight_r <= inflight_nx_s;
      drop_r     <= drop_nx_s;
    end
  end

  if_fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .flush (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({resp_pc_r, cache_rdata_i}),
    .rdata (fifo_head_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign cache_req_o   = issue_s && !rst;
  assign cache_addr_o  = fetch_pc_r;
  assign queue_valid_o = !fifo_empty_s;
  assign queue_pc_o    = fifo_head_s[2*XLEN-1:XLEN];
  assign queue_inst_o  = fifo_head_s[XLEN-1:0];

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a one-cycle-latency in-order I-cache model.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        cache_req_o;
  logic [31:0] cache_addr_o;
  logic        cache_gnt_i;
  logic        cache_rvalid_i;
  logic [31:0] cache_rdata_i;
  logic        queue_valid_o;
  logic [31:0] queue_inst_o;
  logic [31:0] queue_pc_o;
  logic        queue_ready_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  logic        last_req;
  logic [31:0] pend_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  if_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .cache_req_o    (cache_req_o),
    .cache_addr_o   (cache_addr_o),
    .cache_gnt_i    (cache_gnt_i),
    .cache_rvalid_i (cache_rvalid_i),
    .cache_rdata_i  (cache_rdata_i),
    .queue_valid_o  (queue_valid_o),
    .queue_inst_o   (queue_inst_o),
    .queue_pc_o     (queue_pc_o),
    .queue_ready_i  (queue_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic logic [31:0] got_pc_at(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] got_inst_at(input int i);
    return (i < got_inst.size()) ? got_inst[i] : 32'hFFFF_FFFF;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic g, input logic r, input logic rd, input logic rdy_v,
                       input logic redir, input logic [31:0] rpc);
    logic        acc;
    logic [31:0] acc_addr;
    rdy           = rdy_v;
    cache_gnt_i   = g;
    queue_ready_i = rd;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    if (r && rdy_v && pend_q.size() > 0) begin
      cache_rvalid_i = 1'b1;
      cache_rdata_i  = inst_of(pend_q[0]);
    end else begin
      cache_rvalid_i = 1'b0;
      cache_rdata_i  = 32'h0;
    end
    #2;
    acc      = cache_req_o && g && rdy_v;
    acc_addr = cache_addr_o;
    last_req = cache_req_o;
    if (queue_valid_o && rd && rdy_v && !redir) begin
      got_pc.push_back(queue_pc_o);
      got_inst.push_back(queue_inst_o);
    end
    @(posedge clk);
    if (cache_rvalid_i) void'(pend_q.pop_front());
    if (acc) begin
      pend_q.push_back(acc_addr);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    cache_gnt_i = 1'b0; cache_rvalid_i = 1'b0; cache_rdata_i = 32'h0; queue_ready_i = 1'b0;
    @(negedge clk);
    pend_q.delete(); got_pc.delete(); got_inst.delete(); n_acc = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    cache_gnt_i = 1'b0; cache_rvalid_i = 1'b0; cache_rdata_i = 32'h0; queue_ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (cache_req_o !== 1'b0) $display("FAIL reset_req: got %0b want 0", cache_req_o); else n_pass++;
    n_checks++; if (cache_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", cache_addr_o); else n_pass++;
    n_checks++; if (queue_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b want 0", queue_valid_o); else n_pass++;
    n_checks++; if (queue_pc_o !== 32'h0) $display("FAIL reset_pc: got %h want 0", queue_pc_o); else n_pass++;
    n_checks++; if (queue_inst_o !== 32'h0) $display("FAIL reset_inst: got %h want 0", queue_inst_o); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    stream(10);
    n_checks++; if (got_pc.size() != 8) $display("FAIL stream_count: got %0d want 8", got_pc.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_pc_at(i) !== 32'(4 * i) || got_inst_at(i) !== inst_of(32'(4 * i)))
        $display("FAIL stream_word%0d: got pc %h inst %h want pc %h inst %h", i, got_pc_at(i),
                 got_inst_at(i), 32'(4 * i), inst_of(32'(4 * i)));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++; if (n_acc != 4) $display("FAIL bp_issued: got %0d want 4", n_acc); else n_pass++;
    n_checks++; if (cache_req_o !== 1'b0) $display("FAIL bp_req_low: got %0b want 0", cache_req_o); else n_pass++;
    n_checks++; if (cache_addr_o !== 32'h10) $display("FAIL bp_addr: got %h want 10", cache_addr_o); else n_pass++;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++; if (got_pc_at(0) !== 32'h0) $display("FAIL bp_pop_pc: got %h want 0", got_pc_at(0)); else n_pass++;
    n_checks++; if (cache_req_o !== 1'b1) $display("FAIL bp_req_credit: got %0b want 1", cache_req_o); else n_pass++;
  endtask

  task automatic test_redirect_drop();
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++; if (pend_q.size() != 2) $display("FAIL rd_inflight: got %0d want 2", pend_q.size()); else n_pass++;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    stream(8);
    n_checks++; if (got_pc_at(0) !== 32'h100 || got_inst_at(0) !== inst_of(32'h100))
      $display("FAIL rd_first: got pc %h inst %h want pc 100 inst %h", got_pc_at(0), got_inst_at(0), inst_of(32'h100));
    else n_pass++;
    n_checks++; if (got_pc_at(1) !== 32'h104) $display("FAIL rd_second: got %h want 104", got_pc_at(1)); else n_pass++;
  endtask

  task automatic test_redirect_unaligned();
    do_reset();
    stream(4);
    got_pc.delete(); got_inst.delete();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h103);
    n_checks++; if (last_req !== 1'b0) $display("FAIL ru_req_forced: got %0b want 0", last_req); else n_pass++;
    n_checks++; if (cache_addr_o !== 32'h100) $display("FAIL ru_addr: got %h want 100", cache_addr_o); else n_pass++;
    stream(5);
    n_checks++; if (got_pc.size() != 3) $display("FAIL ru_count: got %0d want 3", got_pc.size()); else n_pass++;
    n_checks++; if (got_pc_at(0) !== 32'h100 || got_inst_at(0) !== inst_of(32'h100))
      $display("FAIL ru_first: got pc %h inst %h want pc 100 inst %h", got_pc_at(0), got_inst_at(0), inst_of(32'h100));
    else n_pass++;
    n_checks++; if (got_pc_at(2) !== 32'h108) $display("FAIL ru_third: got %h want 108", got_pc_at(2)); else n_pass++;
  endtask

  task automatic test_gnt_stall();
    do_reset();
    stream(4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      n_checks++; if (cache_addr_o !== 32'h10) $display("FAIL stall_addr%0d: got %h want 10", i, cache_addr_o); else n_pass++;
    end
    n_checks++; if (pend_q.size() != 1) $display("FAIL stall_inflight: got %0d want 1", pend_q.size()); else n_pass++;
    stream(8);
    n_checks++; if (got_pc.size() != 10) $display("FAIL stall_count: got %0d want 10", got_pc.size()); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (got_pc_at(i) !== 32'(4 * i)) $display("FAIL stall_seq%0d: got %h want %h", i, got_pc_at(i), 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    stream(4);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (cache_req_o !== 1'b1) $display("FAIL frz_req: got %0b want 1", cache_req_o); else n_pass++;
    n_checks++; if (cache_addr_o !== 32'h10) $display("FAIL frz_addr: got %h want 10", cache_addr_o); else n_pass++;
    n_checks++; if (queue_valid_o !== 1'b1) $display("FAIL frz_valid: got %0b want 1", queue_valid_o); else n_pass++;
    n_checks++; if (queue_pc_o !== 32'h8 || queue_inst_o !== inst_of(32'h8))
      $display("FAIL frz_head: got pc %h inst %h want pc 8 inst %h", queue_pc_o, queue_inst_o, inst_of(32'h8));
    else n_pass++;
    stream(8);
    n_checks++; if (got_pc.size() != 10) $display("FAIL frz_count: got %0d want 10", got_pc.size()); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (got_pc_at(i) !== 32'(4 * i)) $display("FAIL frz_seq%0d: got %h want %h", i, got_pc_at(i), 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    stream(6);
    rst = 1'b1;
    #1;
    n_checks++; if (cache_addr_o !== 32'h0) $display("FAIL mrst_addr: got %h want 0", cache_addr_o); else n_pass++;
    n_checks++; if (queue_valid_o !== 1'b0) $display("FAIL mrst_valid: got %0b want 0", queue_valid_o); else n_pass++;
    do_reset();
    stream(3);
    n_checks++; if (got_pc.size() != 1 || got_pc_at(0) !== 32'h0)
      $display("FAIL mrst_restart: got %0d words first pc %h want 1 word pc 0", got_pc.size(), got_pc_at(0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_unaligned();
    test_gnt_stall();
    test_rdy_freeze();
    test_midstream_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
